// File: rtl/led_pattern_pkg.sv
// Mode encodings and shared constants for the LED pattern generator.
package led_pattern_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_RESET       = 3'd0,
      MODE_SHIFT_LEFT  = 3'd1,
      MODE_SHIFT_RIGHT = 3'd2,
      MODE_PAUSE       = 3'd3,
      MODE_BOUNCE      = 3'd4
   } mode_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Base-tick prescaler plus power-of-two step divider for the LED pattern generator.
module led_tick_gen #(
   parameter int PERIOD = 125000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [1:0] speed,
   output logic       step
);

   localparam int             PW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0]  LAST = PW'(PERIOD - 1);

   logic [PW-1:0] r_presc;
   logic [2:0]    r_div;
   logic          w_base;
   logic          w_div_done;
   logic [3:0]    w_div_inc;
   logic [3:0]    w_thresh;

   assign w_base     = (r_presc == LAST);
   assign w_thresh   = 4'd1 << speed;
   assign w_div_inc  = {1'b0, r_div} + 4'd1;
   // >= rather than == so a speed drop below the running count fires on the next tick
   assign w_div_done = (w_div_inc >= w_thresh);
   assign step       = w_base && w_div_done && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_div   <= '0;
      end else if (clr) begin
         r_presc <= '0;
         r_div   <= '0;
      end else begin
         r_presc <= w_base ? '0 : r_presc + PW'(1);
         if (w_base)
            r_div <= w_div_done ? 3'd0 : w_div_inc[2:0];
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: button-selected mode applied to the pattern on each divided step.
// Optional BOUNCE mode and its direction register are built when LED_PATTERN_BOUNCE_EN is defined.
//
// state            | meaning
// MODE_RESET       | each step reloads INIT_PATTERN
// MODE_SHIFT_LEFT  | each step rotates the pattern left
// MODE_SHIFT_RIGHT | each step rotates the pattern right
// MODE_PAUSE       | steps keep pulsing, pattern held
// MODE_BOUNCE      | zero-fill shift, direction reverses at the ends
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int                N_LEDS       = 8,
   parameter int                PERIOD       = 125000000,
   parameter logic [N_LEDS-1:0] INIT_PATTERN = N_LEDS'(2'b11)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        btn,
   input  logic [1:0]        speed,
   output logic [N_LEDS-1:0] leds,
   output logic              step,
   output logic [MODE_W-1:0] mode
);

   mode_t             r_mode;
   mode_t             w_mode_nxt;
   logic [N_LEDS-1:0] r_leds;
   logic [N_LEDS-1:0] w_leds_nxt;
   logic              r_step;
   logic              w_fire;

   led_tick_gen #(.PERIOD(PERIOD)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (btn[0]),
      .speed (speed),
      .step  (w_fire)
   );

`ifdef LED_PATTERN_BOUNCE_EN
   logic r_dir;
   logic w_dir_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_dir <= DIR_LEFT;
      else        r_dir <= w_dir_nxt;
   end
`else
   logic w_unused_btn;
   assign w_unused_btn = btn[4];
`endif

   always_comb begin
      w_mode_nxt = r_mode;
      if      (btn[0]) w_mode_nxt = MODE_RESET;
      else if (btn[1]) w_mode_nxt = MODE_SHIFT_LEFT;
      else if (btn[2]) w_mode_nxt = MODE_SHIFT_RIGHT;
      else if (btn[3]) w_mode_nxt = MODE_PAUSE;
`ifdef LED_PATTERN_BOUNCE_EN
      else if (btn[4]) w_mode_nxt = MODE_BOUNCE;
`endif
   end

   // r_mode (not w_mode_nxt) drives the step so a same-cycle mode change takes effect next step
   always_comb begin
      w_leds_nxt = r_leds;
`ifdef LED_PATTERN_BOUNCE_EN
      w_dir_nxt  = r_dir;
`endif
      if (btn[0]) begin
         w_leds_nxt = INIT_PATTERN;
`ifdef LED_PATTERN_BOUNCE_EN
         w_dir_nxt  = DIR_LEFT;
`endif
      end else if (w_fire) begin
         case (r_mode)
            MODE_RESET:       w_leds_nxt = INIT_PATTERN;
            MODE_SHIFT_LEFT:  w_leds_nxt = {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]};
            MODE_SHIFT_RIGHT: w_leds_nxt = {r_leds[0], r_leds[N_LEDS-1:1]};
            MODE_PAUSE:       w_leds_nxt = r_leds;
`ifdef LED_PATTERN_BOUNCE_EN
            MODE_BOUNCE: begin
               if (r_leds == '0 || (r_leds[N_LEDS-1] && r_leds[0])) begin
                  w_leds_nxt = r_leds;
               end else if (r_dir == DIR_LEFT) begin
                  if (r_leds[N_LEDS-1]) begin
                     w_dir_nxt  = DIR_RIGHT;
                     w_leds_nxt = r_leds >> 1;
                  end else begin
                     w_leds_nxt = r_leds << 1;
                  end
               end else begin
                  if (r_leds[0]) begin
                     w_dir_nxt  = DIR_LEFT;
                     w_leds_nxt = r_leds << 1;
                  end else begin
                     w_leds_nxt = r_leds >> 1;
                  end
               end
            end
`endif
            default:          w_leds_nxt = r_leds;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= MODE_RESET;
         r_leds <= INIT_PATTERN;
         r_step <= 1'b0;
      end else begin
         r_mode <= w_mode_nxt;
         r_leds <= w_leds_nxt;
         r_step <= w_fire;
      end
   end

   assign leds = r_leds;
   assign step = r_step;
   assign mode = r_mode;

endmodule
